serial_link_obi_arbiter: RTL and testbench
==========================================

Name: serial_link_obi_arbiter

Overview:
Shares the single OBI slave port of the serial-link wrapper (the outbound transaction path into the link) between NumReq OBI masters, e.g. core data port and DMA.
- Arbitrates address phases round-robin.
- Keeps the selected request stable until it is granted.
- Tracks issue order in an ID FIFO so each downstream rvalid/rdata is routed to the master that issued the matching request.
- Sits in the system-bus clock domain, between the masters and the wrapper's OBI input.

Parameters:
NumReq, 2, number of upstream OBI masters (2..8)
AddrWidth, 32, OBI address width
DataWidth, 32, OBI data width; byte-enable width is DataWidth/8
MaxOutstanding, 4, ID FIFO depth = max accepted-but-unanswered transactions (power of 2, >=2)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumReq  upstream OBI req per master
addr_i  in  NumReq*AddrWidth  upstream addresses, packed, master k at [k*AddrWidth +: AddrWidth]
we_i  in  NumReq  upstream write enables
be_i  in  NumReq*DataWidth/8  upstream byte enables
wdata_i  in  NumReq*DataWidth  upstream write data
gnt_o  out  NumReq  upstream grants
rvalid_o  out  NumReq  upstream response valids
rdata_o  out  DataWidth  response data, common to all masters; qualified by rvalid_o
sl_req_o  out  1  downstream req to serial-link wrapper
sl_addr_o  out  AddrWidth  downstream address
sl_we_o  out  1  downstream write enable
sl_be_o  out  DataWidth/8  downstream byte enable
sl_wdata_o  out  DataWidth  downstream write data
sl_gnt_i  in  1  downstream grant
sl_rvalid_i  in  1  downstream response valid
sl_rdata_i  in  DataWidth  downstream response data
outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO fill level
err_unexp_rsp_o  out  1  sticky: sl_rvalid_i arrived while FIFO empty

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous, active-low (rst_ni).
- Reset values:
  - rr pointer = 0, so master 0 has highest priority.
  - lock = 0, FIFO empty, outstanding_o = 0, err_unexp_rsp_o = 0.
  - Combinational outputs are 0 whenever all req_i = 0 and sl_rvalid_i = 0.
- Selection (when lock = 0):
  - Pick the first k with req_i[k] = 1, searching cyclically from rr pointer.
  - Select logic is combinational, same cycle as req_i.
- Downstream drive:
  - sl_req_o = (any selected request) AND NOT fifo_full.
  - sl_addr/we/be/wdata = fields of the selected master; all zero when none is selected.
- Grant:
  - gnt_o[sel] = sl_gnt_i AND sl_req_o. All other gnt_o bits are 0.
  - No added latency; at most one gnt_o bit is high per cycle.
- Lock (OBI address-phase stability):
  - If sl_req_o = 1 and sl_gnt_i = 0, set lock = 1 and store sel.
  - While lock = 1, sel is the stored index regardless of other req_i.
  - Lock clears on the handshake cycle.
- Handshake (sl_req_o and sl_gnt_i):
  - Push sel into the ID FIFO.
  - rr pointer <= (sel+1) mod NumReq.
  - lock <= 0.
- Full FIFO:
  - When fifo_full, sl_req_o = 0 and no grant is issued, even if a pop occurs in the same cycle.
  - The request is retried the next cycle.
  - The lock state is held while full.
- Response path:
  - On sl_rvalid_i with FIFO non-empty: rvalid_o[head] = 1 in the same cycle, rdata_o = sl_rdata_i, pop head.
  - Push and pop in the same cycle are allowed when not full; outstanding_o is unchanged in that case.
- Unexpected response:
  - sl_rvalid_i with FIFO empty: no rvalid_o is asserted.
  - err_unexp_rsp_o is set and stays set until reset.
- Fairness: the rr pointer guarantees a master that holds req is granted within NumReq handshakes.
- Masters that deassert req before grant (OBI violation) are not supported; the lock still holds the stored index.
- Reset mid-transaction: all state clears immediately; responses that are in flight are later flagged via err_unexp_rsp_o.

Decomposition:
- Shared package serial_link_arb_pkg holds:
  - derived widths IdxWidth = $clog2(NumReq) and CntWidth;
  - function rr_pick(req, ptr) returning the index.
- One sub-module, serial_link_arb_id_fifo: synchronous FIFO of IdxWidth entries with full/empty/usage outputs and async reset.
  - Reusing common_cells fifo_v3 with FALL_THROUGH = 0 is acceptable.

Test Plan:
- Reset: all req_i = 0 -> sl_req_o = 0, gnt_o = 0, outstanding_o = 0, err_unexp_rsp_o = 0.
- Round-robin:
  - Stimulus: NumReq = 2, both masters hold req, sl_gnt_i = 1 every cycle, rvalid returned 1 cycle later.
  - Required: grants alternate 0,1,0,1; rvalid_o routed 0,1,0,1 with rdata_o matching.
- Lock:
  - Stimulus: master 1 requests addr 0x100 alone, sl_gnt_i = 0 for 3 cycles; master 0 raises req in cycle 1.
  - Required: sl_addr_o stays 0x100 for all 4 cycles; gnt_o[1] in cycle 3; master 0 granted next.
- Full:
  - Stimulus: MaxOutstanding = 4, 5 back-to-back writes from master 0, no rvalid.
  - Required: 4 grants, outstanding_o = 4, sl_req_o = 0 on the 5th.
  - Then one rvalid: the 5th request is granted the cycle after the pop.
- Simultaneous push/pop: at fill 2, a handshake and an rvalid in the same cycle -> outstanding_o stays 2; the FIFO head advances correctly.
- Unexpected response: sl_rvalid_i pulsed with FIFO empty -> all rvalid_o = 0; err_unexp_rsp_o = 1 and it remains 1 until rst_ni asserts.

Source files
------------

// File: rtl/serial_link_arb_pkg.sv
// rtl/serial_link_arb_pkg.sv - shared widths and round-robin pick helper for the serial-link OBI arbiter
package serial_link_arb_pkg;

    localparam int unsigned MaxReq      = 8;
    localparam int unsigned MaxIdxWidth = 3;

    typedef logic [MaxIdxWidth-1:0] idx_t;

    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Walk from the farthest candidate back to ptr so the closest requester wins.
    function automatic idx_t rr_pick(input logic [MaxReq-1:0] req, input idx_t ptr,
                                     input int unsigned num_req);
        idx_t        pick;
        idx_t        cand_idx;
        int unsigned cand;
        pick = ptr;
        for (int i = MaxReq - 1; i >= 0; i--) begin
            if (i < int'(num_req)) begin
                cand     = (32'(ptr) + 32'(i)) % num_req;
                cand_idx = cand[MaxIdxWidth-1:0];
                if (req[cand_idx]) begin
                    pick = cand_idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/serial_link_arb_id_fifo.sv
// rtl/serial_link_arb_id_fifo.sv - ID FIFO recording which master issued each outstanding transaction
module serial_link_arb_id_fifo
    import serial_link_arb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [Width-1:0]             push_data,
    input  logic                         pop,
    output logic [Width-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   usage
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = cnt_width(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CntWidth'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign usage   = count;

    // Depth is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// rtl/serial_link_obi_arbiter.sv - round-robin OBI arbiter in front of the serial-link wrapper slave port
module serial_link_obi_arbiter
    import serial_link_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq*AddrWidth-1:0]          addr_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq*DataWidth/8-1:0]        be_i,
    input  logic [NumReq*DataWidth-1:0]          wdata_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 sl_req_o,
    output logic [AddrWidth-1:0]                 sl_addr_o,
    output logic                                 sl_we_o,
    output logic [DataWidth/8-1:0]               sl_be_o,
    output logic [DataWidth-1:0]                 sl_wdata_o,
    input  logic                                 sl_gnt_i,
    input  logic                                 sl_rvalid_i,
    input  logic [DataWidth-1:0]                 sl_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 err_unexp_rsp_o
);

    localparam int unsigned IdxWidth = idx_width(NumReq);
    localparam int unsigned BeWidth  = DataWidth / 8;

    logic                lock_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic [IdxWidth-1:0] rr_ptr_q;
    logic [IdxWidth-1:0] sel;
    logic [IdxWidth-1:0] head;
    logic [MaxReq-1:0]   req_pad;
    idx_t                ptr_pad;
    idx_t                pick;
    logic                any_sel;
    logic                fifo_full;
    logic                fifo_empty;
    logic                handshake;
    logic                pop;

    always_comb begin
        req_pad                 = '0;
        req_pad[NumReq-1:0]     = req_i;
        ptr_pad                 = '0;
        ptr_pad[IdxWidth-1:0]   = rr_ptr_q;
        pick                    = rr_pick(req_pad, ptr_pad, NumReq);
    end

    // A stalled address phase keeps its master even if others raise req meanwhile.
    assign sel       = lock_q ? lock_idx_q : pick[IdxWidth-1:0];
    assign any_sel   = lock_q | (|req_i);
    assign sl_req_o  = any_sel & ~fifo_full;
    assign handshake = sl_req_o & sl_gnt_i;
    assign pop       = sl_rvalid_i & ~fifo_empty;

    always_comb begin
        sl_addr_o  = '0;
        sl_we_o    = 1'b0;
        sl_be_o    = '0;
        sl_wdata_o = '0;
        gnt_o      = '0;
        if (any_sel) begin
            sl_addr_o  = addr_i[sel*AddrWidth +: AddrWidth];
            sl_we_o    = we_i[sel];
            sl_be_o    = be_i[sel*BeWidth +: BeWidth];
            sl_wdata_o = wdata_i[sel*DataWidth +: DataWidth];
        end
        if (handshake) begin
            gnt_o[sel] = 1'b1;
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pop) begin
            rvalid_o[head] = 1'b1;
            rdata_o        = sl_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q          <= 1'b0;
            lock_idx_q      <= '0;
            rr_ptr_q        <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            if (handshake) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (sel == IdxWidth'(NumReq - 1)) ? '0 : sel + 1'b1;
            end else if (sl_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (sl_rvalid_i && fifo_empty) begin
                err_unexp_rsp_o <= 1'b1;
            end
        end
    end

    serial_link_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) i_id_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (handshake),
        .push_data (sel),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .usage     (outstanding_o)
    );

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// tb/tb_serial_link_obi_arbiter.sv - directed self-checking bench for serial_link_obi_arbiter
module tb_serial_link_obi_arbiter;

    localparam int NumReq         = 2;
    localparam int AddrWidth      = 32;
    localparam int DataWidth      = 32;
    localparam int MaxOutstanding = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        sl_req;
    logic [31:0] sl_addr;
    logic        sl_we;
    logic [3:0]  sl_be;
    logic [31:0] sl_wdata;
    logic        sl_gnt;
    logic        sl_rvalid;
    logic [31:0] sl_rdata;
    logic [2:0]  outstanding;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_link_obi_arbiter #(
        .NumReq         (NumReq),
        .AddrWidth      (AddrWidth),
        .DataWidth      (DataWidth),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req),
        .addr_i          (addr),
        .we_i            (we),
        .be_i            (be),
        .wdata_i         (wdata),
        .gnt_o           (gnt),
        .rvalid_o        (rvalid),
        .rdata_o         (rdata),
        .sl_req_o        (sl_req),
        .sl_addr_o       (sl_addr),
        .sl_we_o         (sl_we),
        .sl_be_o         (sl_be),
        .sl_wdata_o      (sl_wdata),
        .sl_gnt_i        (sl_gnt),
        .sl_rvalid_i     (sl_rvalid),
        .sl_rdata_i      (sl_rdata),
        .outstanding_o   (outstanding),
        .err_unexp_rsp_o (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
        @(negedge clk);
        req       = r;
        sl_gnt    = g;
        sl_rvalid = v;
        sl_rdata  = d;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        addr      = {32'h0000_00B0, 32'h0000_00A0};
        we        = 2'b00;
        be        = {4'hF, 4'h3};
        wdata     = {32'h2222_2222, 32'h1111_1111};
        sl_gnt    = 1'b0;
        sl_rvalid = 1'b0;
        sl_rdata  = '0;

        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("rst_sl_req", sl_req, 0);
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);
        check("rst_sl_addr", sl_addr, 0);
        rst_n = 1'b1;

        for (int c = 0; c < 5; c++) begin
            drive((c < 4) ? 2'b11 : 2'b00, c < 4, c > 0, 32'(32'h1000 + c - 1));
            check("rr_gnt", gnt, (c < 4) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00);
            check("rr_addr", sl_addr, (c < 4) ? ((c % 2) ? 32'hB0 : 32'hA0) : 32'h0);
            check("rr_be", sl_be, (c < 4) ? ((c % 2) ? 4'hF : 4'h3) : 4'h0);
            check("rr_rvalid", rvalid, (c > 0) ? (((c - 1) % 2) ? 2'b10 : 2'b01) : 2'b00);
            check("rr_rdata", rdata, (c > 0) ? 32'(32'h1000 + c - 1) : 32'h0);
        end
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("rr_drained", outstanding, 0);

        addr = {32'h0000_0100, 32'h0000_0200};
        for (int c = 0; c < 4; c++) begin
            drive((c == 0) ? 2'b10 : 2'b11, c == 3, 1'b0, 32'h0);
            check("lock_addr", sl_addr, 32'h100);
            check("lock_req", sl_req, 1);
            check("lock_gnt", gnt, (c == 3) ? 2'b10 : 2'b00);
        end
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("lock_next_gnt", gnt, 2'b01);
        check("lock_next_addr", sl_addr, 32'h200);
        drive(2'b00, 1'b0, 1'b1, 32'hAAAA);
        check("lock_rsp1_rvalid", rvalid, 2'b10);
        check("lock_rsp1_rdata", rdata, 32'hAAAA);
        drive(2'b00, 1'b0, 1'b1, 32'hBBBB);
        check("lock_rsp2_rvalid", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("lock_drained", outstanding, 0);

        we = 2'b01;
        for (int c = 0; c < 4; c++) begin
            drive(2'b01, 1'b1, 1'b0, 32'h0);
            check("full_gnt", gnt, 2'b01);
            check("full_we", sl_we, 1);
            check("full_wdata", sl_wdata, 32'h1111_1111);
        end
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("full_blocked_req", sl_req, 0);
        check("full_blocked_gnt", gnt, 0);
        check("full_level", outstanding, 4);
        drive(2'b01, 1'b1, 1'b1, 32'h55);
        check("full_pop_req", sl_req, 0);
        check("full_pop_gnt", gnt, 0);
        check("full_pop_rvalid", rvalid, 2'b01);
        check("full_pop_rdata", rdata, 32'h55);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("full_retry_req", sl_req, 1);
        check("full_retry_gnt", gnt, 2'b01);
        check("full_retry_level", outstanding, 3);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("full_refill", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b1, 32'(32'h60 + i));
            check("full_drain_rvalid", rvalid, 2'b01);
            check("full_drain_rdata", rdata, 32'(32'h60 + i));
        end
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("full_drained", outstanding, 0);
        we = 2'b00;

        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("pp_gnt_a", gnt, 2'b10);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("pp_gnt_b", gnt, 2'b01);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("pp_fill", outstanding, 2);
        drive(2'b10, 1'b1, 1'b1, 32'h77);
        check("pp_gnt", gnt, 2'b10);
        check("pp_rvalid", rvalid, 2'b10);
        check("pp_rdata", rdata, 32'h77);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("pp_level", outstanding, 2);
        drive(2'b00, 1'b0, 1'b1, 32'h88);
        check("pp_head1", rvalid, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 32'h99);
        check("pp_head2", rvalid, 2'b10);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("pp_drained", outstanding, 0);

        drive(2'b00, 1'b0, 1'b1, 32'hCC);
        check("unexp_rvalid", rvalid, 2'b00);
        check("unexp_rdata", rdata, 32'h0);
        check("unexp_err_before_edge", err, 0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("unexp_err_set", err, 1);
        repeat (3) drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("unexp_err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        check("unexp_err_reset", err, 0);
        check("reset_level", outstanding, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
